// File: rtl/ingress_pkt_guard_pkg.sv
// Shared definitions for the buffer path.
// Holds the sideband field layout so buffer_top and the egress side decode the
// same bit positions, and the ingress guard FSM state enum.
package buffer_pkg;

  // Flow id occupies the low bits of the sideband; the truncation flag sits
  // directly above it.
  localparam int SB_FLOW_LSB = 0;

  function automatic int sb_trunc_bit(input int flow_w);
    return SB_FLOW_LSB + flow_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2,
    DROP  = 2'd3
  } guard_state_e;

endpackage

// File: rtl/ingress_pkt_guard_if.sv
// Generic stream bundle used on both sides of the ingress guard.
// Ports / members:
//   data  : payload beat
//   valid : beat present
//   ready : sink accepts beat
//   last  : end of packet
//   user  : per-beat side information (flow id on the source side,
//           sideband on the buffer side)
// Modports: master drives data/valid/last/user, slave drives ready.
interface ingress_pkt_guard_if #(
  parameter int DW = 64,
  parameter int UW = 4
) ();
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;
  logic [UW-1:0] user;

  modport master (output data, output valid, output last, output user, input ready);
  modport slave  (input data, input valid, input last, input user, output ready);
endinterface

// File: rtl/ingress_pkt_guard_axis_reg_slice.sv
// axis_reg_slice: single-entry registered stage with valid/ready.
// Ports:
//   clk, rst_n           : clock, asynchronous active-high reset
//   in_data/in_valid     : upstream payload and valid
//   in_ready             : upstream may push this cycle
//   out_data/out_valid   : registered payload and valid
//   out_ready            : downstream accepts the held beat
// Full throughput: a new beat can be loaded in the same cycle the held one
// leaves. The held beat is stable while out_valid=1 and out_ready=0.
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ingress_pkt_guard.sv
// ingress_pkt_guard: ingress stage in front of buffer_top's write port.
// Bounds packet length to MAX_BEATS (truncating with a forced last beat and
// discarding the tail), builds the sideband (flow id + truncation flag) and
// drops whole packets that start while cfg_enable is low.
// Ports:
//   clk, rst_n        : clock, asynchronous active-high reset
//   cfg_enable        : sampled on the first beat of each packet
//   s_axis (slave)    : source stream, user = flow id
//   m_axis (master)   : to buffer_top s_w*, user = sideband
//   stat_*_cnt        : saturating forwarded / truncated / dropped counters
//
// state | meaning
// IDLE  | between packets; next accepted beat is a first beat
// PASS  | forwarding a packet, beat_q beats already sent
// DRAIN | truncated packet closed; discard until source last
// DROP  | packet started while disabled; discard until source last
module ingress_pkt_guard
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int SB_WIDTH   = 10,
  parameter int FLOW_W     = 4,
  parameter int MAX_BEATS  = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  ingress_pkt_guard_if.slave  s_axis,
  ingress_pkt_guard_if.master m_axis,
  output logic [CNT_W-1:0] stat_pkt_cnt,
  output logic [CNT_W-1:0] stat_trunc_cnt,
  output logic [CNT_W-1:0] stat_drop_cnt
);

  localparam int BCW          = $clog2(MAX_BEATS + 1);
  localparam int SB_TRUNC_BIT = sb_trunc_bit(FLOW_W);
  localparam int PW           = DATA_WIDTH + 1 + SB_WIDTH;

  guard_state_e       state_q, state_n;
  logic [BCW-1:0]     beat_q, beat_n;
  logic [FLOW_W-1:0]  flow_q, flow_n;

  logic               acc;
  logic               fwd;
  logic               out_last;
  logic               trunc;
  logic               inc_pkt, inc_trunc, inc_drop;
  logic               slice_ready;
  logic [SB_WIDTH-1:0] sb;
  logic [PW-1:0]      out_payload;

  // Discarding states never stall the source.
  assign s_axis.ready = (state_q == DRAIN || state_q == DROP) ? 1'b1 : slice_ready;
  assign acc          = s_axis.valid && s_axis.ready;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      flow_q  <= '0;
    end else begin
      state_q <= state_n;
      beat_q  <= beat_n;
      flow_q  <= flow_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    beat_n    = beat_q;
    flow_n    = flow_q;
    fwd       = 1'b0;
    out_last  = 1'b0;
    trunc     = 1'b0;
    inc_pkt   = 1'b0;
    inc_trunc = 1'b0;
    inc_drop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (cfg_enable) begin
            fwd      = 1'b1;
            flow_n   = s_axis.user;
            beat_n   = BCW'(1);
            out_last = s_axis.last;
            if (s_axis.last) inc_pkt = 1'b1;
            else             state_n = PASS;
          end else begin
            if (s_axis.last) inc_drop = 1'b1;
            else             state_n  = DROP;
          end
        end
      end
      PASS: begin
        if (acc) begin
          fwd    = 1'b1;
          beat_n = beat_q + BCW'(1);
          if (s_axis.last) begin
            out_last = 1'b1;
            inc_pkt  = 1'b1;
            state_n  = IDLE;
          end else if (beat_q == BCW'(MAX_BEATS - 1)) begin
            // Source last on exactly the MAX_BEATS-th beat takes the branch
            // above, so only genuinely over-length packets land here.
            out_last  = 1'b1;
            trunc     = 1'b1;
            inc_pkt   = 1'b1;
            inc_trunc = 1'b1;
            state_n   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (acc && s_axis.last) state_n = IDLE;
      end
      DROP: begin
        if (acc && s_axis.last) begin
          inc_drop = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // flow_n equals the incoming flow on a first beat and the latched flow
  // afterwards, so every beat of a packet carries the same id.
  always_comb begin
    sb                              = '0;
    sb[SB_FLOW_LSB +: FLOW_W]       = flow_n;
    sb[SB_TRUNC_BIT]                = trunc;
  end

  axis_reg_slice #(
    .WIDTH (PW)
  ) u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s_axis.data, out_last, sb}),
    .in_valid  (fwd),
    .in_ready  (slice_ready),
    .out_data  (out_payload),
    .out_valid (m_axis.valid),
    .out_ready (m_axis.ready)
  );

  assign m_axis.data = out_payload[PW-1 -: DATA_WIDTH];
  assign m_axis.last = out_payload[SB_WIDTH];
  assign m_axis.user = out_payload[SB_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      stat_pkt_cnt   <= '0;
      stat_trunc_cnt <= '0;
      stat_drop_cnt  <= '0;
    end else begin
      if (inc_pkt && stat_pkt_cnt != '1)     stat_pkt_cnt   <= stat_pkt_cnt + CNT_W'(1);
      if (inc_trunc && stat_trunc_cnt != '1) stat_trunc_cnt <= stat_trunc_cnt + CNT_W'(1);
      if (inc_drop && stat_drop_cnt != '1)   stat_drop_cnt  <= stat_drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ingress_pkt_guard.sv
module tb_ingress_pkt_guard;

  localparam int DW   = 64;
  localparam int FW   = 4;
  localparam int SBW  = 10;
  localparam int MAXB = 64;
  localparam int CW   = 5;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic           l;
    logic [SBW-1:0] sb;
  } beat_t;

  logic clk;
  logic rst_n;
  logic cfg_enable;
  logic [CW-1:0] pkt_cnt, trunc_cnt, drop_cnt;

  ingress_pkt_guard_if #(.DW(DW), .UW(FW))  src_if ();
  ingress_pkt_guard_if #(.DW(DW), .UW(SBW)) dst_if ();

  ingress_pkt_guard #(
    .DATA_WIDTH (DW),
    .SB_WIDTH   (SBW),
    .FLOW_W     (FW),
    .MAX_BEATS  (MAXB),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_enable     (cfg_enable),
    .s_axis         (src_if),
    .m_axis         (dst_if),
    .stat_pkt_cnt   (pkt_cnt),
    .stat_trunc_cnt (trunc_cnt),
    .stat_drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  int    m_pkt = 0, m_trunc = 0, m_drop = 0;
  int    cyc = 0, last_in_cyc = 0, last_out_cyc = 0;
  int    rdy_mode = 0;
  bit    rdy_tog = 1'b0;
  bit    in_fire = 1'b0;
  bit    rdy_seen = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t stall_val;

  function automatic logic [CW-1:0] sat(input int n);
    return (n > (2 ** CW) - 1) ? '1 : CW'(n);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rdy();
    case (rdy_mode)
      0: dst_if.ready = 1'b1;
      1: begin dst_if.ready = rdy_tog; rdy_tog = !rdy_tog; end
      default: dst_if.ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Called at a negedge after inputs are driven; evaluates the handshakes
  // that the next posedge will perform, then advances one cycle.
  task automatic tick();
    beat_t ob;
    #1;
    cyc++;
    ob = {dst_if.data, dst_if.last, dst_if.user};
    if (stall_prev) begin
      chk("stall_valid", 128'(dst_if.valid), 128'(1));
      chk("stall_hold", 128'(ob), 128'(stall_val));
    end
    stall_prev = dst_if.valid && !dst_if.ready;
    stall_val  = ob;
    rdy_seen   = src_if.ready;
    in_fire    = src_if.valid && src_if.ready;
    if (in_fire) last_in_cyc = cyc;
    if (dst_if.valid && dst_if.ready) begin
      last_out_cyc = cyc;
      chk("out_beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        chk("out_beat", 128'(ob), 128'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_pkt_cnt"},   128'(pkt_cnt),   128'(sat(m_pkt)));
    chk({tag, "_trunc_cnt"}, 128'(trunc_cnt), 128'(sat(m_trunc)));
    chk({tag, "_drop_cnt"},  128'(drop_cnt),  128'(sat(m_drop)));
  endtask

  task automatic flush(input string tag);
    src_if.valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !dst_if.valid) break;
      drive_rdy();
      tick();
    end
    chk({tag, "_flush_empty"}, 128'(exp_q.size()), 128'(0));
    check_stats(tag);
  endtask

  // Reference model works on whole packets: forwarded length is
  // min(len, MAXB), last on the final forwarded beat, trunc flag only when
  // the source packet was longer than MAXB.
  task automatic send_pkt(input int len, input logic [FW-1:0] flow, input bit en,
                          input int toggle_at, input int abort_at, input bit gaps);
    logic [DW-1:0] dat[$];
    int n;
    int i;
    for (int k = 0; k < len; k++) dat.push_back({$urandom, $urandom});
    n = (len > MAXB) ? MAXB : len;
    if (en) begin
      for (int k = 0; k < n; k++) begin
        beat_t b;
        b.d  = dat[k];
        b.l  = (k == n - 1);
        b.sb = SBW'(flow) | (((len > MAXB) && (k == n - 1)) ? SBW'(16) : SBW'(0));
        exp_q.push_back(b);
      end
      m_pkt++;
      if (len > MAXB) m_trunc++;
    end else begin
      m_drop++;
    end
    cfg_enable = en;
    i = 0;
    while (i < len) begin
      if (i == abort_at) begin
        rst_n = 1'b1;
        #1;
        chk("rst_m_wvalid", 128'(dst_if.valid), 128'(0));
        chk("rst_m_wlast",  128'(dst_if.last),  128'(0));
        chk("rst_m_wdata",  128'(dst_if.data),  128'(0));
        chk("rst_m_wsb",    128'(dst_if.user),  128'(0));
        chk("rst_s_tready", 128'(src_if.ready), 128'(1));
        exp_q.delete();
        m_pkt = 0; m_trunc = 0; m_drop = 0;
        check_stats("rst");
        stall_prev   = 1'b0;
        src_if.valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        return;
      end
      if (i == toggle_at) cfg_enable = !en;
      if (gaps && $urandom_range(0, 3) == 0) begin
        src_if.valid = 1'b0;
        drive_rdy();
        tick();
      end
      src_if.valid = 1'b1;
      src_if.data  = dat[i];
      src_if.last  = (i == len - 1);
      // Later beats carry junk flow ids; only the first one may be used.
      src_if.user  = (i == 0) ? flow : FW'($urandom);
      in_fire = 1'b0;
      for (int w = 0; w < 100; w++) begin
        drive_rdy();
        tick();
        if ((!en && i > 0) || (en && i >= MAXB))
          chk("discard_tready", 128'(rdy_seen), 128'(1));
        if (in_fire) break;
      end
      chk("beat_accepted", 128'(in_fire), 128'(1));
      i++;
    end
    src_if.valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b1;
    cfg_enable   = 1'b0;
    src_if.valid = 1'b0;
    src_if.data  = '0;
    src_if.last  = 1'b0;
    src_if.user  = '0;
    dst_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_m_wvalid", 128'(dst_if.valid), 128'(0));
    chk("reset_m_wlast",  128'(dst_if.last),  128'(0));
    chk("reset_m_wdata",  128'(dst_if.data),  128'(0));
    chk("reset_m_wsb",    128'(dst_if.user),  128'(0));
    check_stats("reset");
    rst_n = 1'b0;
    @(negedge clk);

    // 5-beat packet, flow 3, sink always ready; one-cycle latency.
    rdy_mode = 0;
    send_pkt(5, 4'd3, 1'b1, -1, -1, 1'b0);
    flush("p5");
    chk("latency", 128'(last_out_cyc - last_in_cyc), 128'(1));

    // 70-beat packet truncated to 64 beats, flow 5.
    rdy_mode = 2;
    send_pkt(70, 4'd5, 1'b1, -1, -1, 1'b0);
    flush("p70");

    // Exactly MAX_BEATS with source last: not truncated.
    send_pkt(64, 4'd7, 1'b1, -1, -1, 1'b1);
    flush("p64");

    // Disabled at start, enabled mid-packet: whole packet dropped.
    send_pkt(10, 4'd2, 1'b0, 4, -1, 1'b0);
    send_pkt(3, 4'd1, 1'b1, -1, -1, 1'b0);
    flush("drop");

    // Alternating backpressure on a 20-beat packet.
    rdy_mode = 1;
    send_pkt(20, 4'd6, 1'b1, -1, -1, 1'b0);
    flush("bp");

    // Reset at beat 7, then a fresh 4-beat packet with flow 9.
    rdy_mode = 2;
    send_pkt(20, 4'd4, 1'b1, -1, 7, 1'b0);
    send_pkt(4, 4'd9, 1'b1, -1, -1, 1'b0);
    flush("post_rst");

    // Randomized packets; enough forwarded packets to saturate counters.
    for (int p = 0; p < 50; p++) begin
      int len;
      len = $urandom_range(1, 80);
      send_pkt(len, FW'($urandom), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, len)) : -1,
               -1, 1'b1);
      if (p % 10 == 9) flush("rand");
    end
    flush("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
